// File: rtl/min2_stream_tracker.sv
// Streaming two-smallest tracker: scans one frame of (index, value) samples and
// reports the two smallest with a one-cycle TriggerBoss pulse one edge after the last sample.
module min2_stream_tracker #(
  parameter int IDX_W = 16,
  parameter int VAL_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic             in_last,
  input  logic [IDX_W-1:0] in_index,
  input  logic [VAL_W-1:0] in_value,
  output logic             MIN2_TriggerBoss,
  output logic [IDX_W-1:0] MIN2_Minimum1Index,
  output logic [VAL_W-1:0] MIN2_Minimum1Value,
  output logic [IDX_W-1:0] MIN2_Minimum2Index,
  output logic [VAL_W-1:0] MIN2_Minimum2Value,
  output logic             busy,
  output logic [IDX_W:0]   sample_count
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IDX_W-1:0] SENT_IDX = '1;
  localparam logic [VAL_W-1:0] SENT_VAL = '1;
  localparam logic [IDX_W:0]   CNT_MAX  = '1;
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] m1_idx_q, m1_idx_d, m2_idx_q, m2_idx_d;
  logic [VAL_W-1:0] m1_val_q, m1_val_d, m2_val_q, m2_val_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             trig_q;
  logic [IDX_W-1:0] o1_idx_q, o2_idx_q;
  logic [VAL_W-1:0] o1_val_q, o2_val_q;
  logic [IDX_W:0]   ocnt_q;

  logic start_new, upd;

  // A start sample always opens a fresh frame, aborting any open one.
  assign start_new = in_valid && in_start;
  assign upd       = in_valid && !in_start && (state_q == SCAN);

  always_comb begin
    state_d  = state_q;
    m1_idx_d = m1_idx_q;
    m1_val_d = m1_val_q;
    m2_idx_d = m2_idx_q;
    m2_val_d = m2_val_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (start_new) begin
      m1_idx_d = in_index;
      m1_val_d = in_value;
      m2_idx_d = SENT_IDX;
      m2_val_d = SENT_VAL;
      cnt_d    = CNT_ONE;
      state_d  = in_last ? IDLE : SCAN;
      done_d   = in_last;
    end else if (upd) begin
      // Strict compares: ties leave the earlier sample in its rank.
      if (in_value < m1_val_q) begin
        m2_idx_d = m1_idx_q;
        m2_val_d = m1_val_q;
        m1_idx_d = in_index;
        m1_val_d = in_value;
      end else if (in_value < m2_val_q) begin
        m2_idx_d = in_index;
        m2_val_d = in_value;
      end
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      if (in_last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m1_idx_q <= SENT_IDX;
      m1_val_q <= SENT_VAL;
      m2_idx_q <= SENT_IDX;
      m2_val_q <= SENT_VAL;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m1_idx_q <= m1_idx_d;
      m1_val_q <= m1_val_d;
      m2_idx_q <= m2_idx_d;
      m2_val_q <= m2_val_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // Results are captured from the running registers one edge after completion,
  // before a following frame's first sample can be seen in them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q   <= 1'b0;
      o1_idx_q <= '0;
      o1_val_q <= '0;
      o2_idx_q <= '0;
      o2_val_q <= '0;
      ocnt_q   <= '0;
    end else begin
      trig_q <= done_q;
      if (done_q) begin
        o1_idx_q <= m1_idx_q;
        o1_val_q <= m1_val_q;
        o2_idx_q <= m2_idx_q;
        o2_val_q <= m2_val_q;
        ocnt_q   <= cnt_q;
      end
    end
  end

  assign MIN2_TriggerBoss   = trig_q;
  assign MIN2_Minimum1Index = o1_idx_q;
  assign MIN2_Minimum1Value = o1_val_q;
  assign MIN2_Minimum2Index = o2_idx_q;
  assign MIN2_Minimum2Value = o2_val_q;
  assign sample_count       = ocnt_q;
  assign busy               = (state_q == SCAN);

endmodule

// File: tb/tb_min2_stream_tracker.sv
// Self-checking bench for min2_stream_tracker: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_min2_stream_tracker;

  localparam int IDX_W = 16;
  localparam int VAL_W = 14;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [VAL_W-1:0] val;
  } smp_t;

  localparam smp_t SENT = '{idx: '1, val: '1};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_start = 1'b0, in_last = 1'b0;
  logic [IDX_W-1:0] in_index = '0;
  logic [VAL_W-1:0] in_value = '0;
  logic             trig, busy;
  logic [IDX_W-1:0] m1i, m2i;
  logic [VAL_W-1:0] m1v, m2v;
  logic [IDX_W:0]   cnt;

  int n_cmp = 0;
  int n_err = 0;

  min2_stream_tracker #(.IDX_W(IDX_W), .VAL_W(VAL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_start(in_start), .in_last(in_last),
    .in_index(in_index), .in_value(in_value),
    .MIN2_TriggerBoss(trig),
    .MIN2_Minimum1Index(m1i), .MIN2_Minimum1Value(m1v),
    .MIN2_Minimum2Index(m2i), .MIN2_Minimum2Value(m2v),
    .busy(busy), .sample_count(cnt)
  );

  always #5 clk = ~clk;

  wire [77:0] obs = {trig, m1i, m1v, m2i, m2v, cnt};

  // Reference model: collects the open frame's samples and ranks them at the end.
  smp_t           cur[$];
  bit             open_m, pend, exp_trig, exp_busy;
  smp_t           p1, p2, e1, e2;
  logic [IDX_W:0] pcnt, ecnt;

  // The sentinel competes for second place as if it sat right after the first
  // sample; the two smallest are then picked with earliest-wins on ties.
  function automatic void rank(input smp_t q[$], output smp_t a, output smp_t b);
    smp_t l[$];
    int ia, ib;
    l = q;
    l.insert(1, SENT);
    ia = 0;
    for (int i = 1; i < l.size(); i++) if (l[i].val < l[ia].val) ia = i;
    ib = (ia == 0) ? 1 : 0;
    for (int i = 0; i < l.size(); i++) if (i != ia && l[i].val < l[ib].val) ib = i;
    a = l[ia];
    b = l[ib];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur.delete();
      open_m = 0; pend = 0; exp_trig = 0; exp_busy = 0;
      e1 = '0; e2 = '0; ecnt = '0;
    end else begin
      exp_trig = pend;
      if (pend) begin e1 = p1; e2 = p2; ecnt = pcnt; end
      pend = 0;
      if (in_valid) begin
        if (in_start) begin
          cur.delete();
          cur.push_back('{idx: in_index, val: in_value});
          open_m = 1;
        end else if (open_m) begin
          cur.push_back('{idx: in_index, val: in_value});
        end
        if (in_last && open_m) begin
          rank(cur, p1, p2);
          pcnt = (cur.size() > 131071) ? '1 : (IDX_W+1)'(cur.size());
          pend = 1;
          open_m = 0;
          cur.delete();
        end
      end
      exp_busy = open_m;
    end
  end

  task automatic send(input bit s, input bit l, input int idx, input int val);
    in_valid = 1'b1; in_start = s; in_last = l;
    in_index = IDX_W'(idx); in_value = VAL_W'(val);
    @(posedge clk); #1;
    in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_por();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (obs !== 78'd0) begin n_err++; $display("FAIL por_outputs: got %h want 0", obs); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL por_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_basic();
    send(1, 0, 0, 50);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_open: got %b want 1", busy); end
    send(0, 0, 1, 20);
    send(0, 0, 2, 70);
    send(0, 1, 3, 10);
    n_cmp++; if ({trig, busy} !== 2'b00) begin n_err++; $display("FAIL basic_last_edge: got trig,busy=%b want 00", {trig, busy}); end
    idle();
    n_cmp++; if (obs !== {1'b1, 16'd3, 14'd10, 16'd1, 14'd20, 17'd4})
      begin n_err++; $display("FAIL basic_result: got %h want %h", obs, {1'b1, 16'd3, 14'd10, 16'd1, 14'd20, 17'd4}); end
    idle();
    n_cmp++; if (obs !== {1'b0, 16'd3, 14'd10, 16'd1, 14'd20, 17'd4})
      begin n_err++; $display("FAIL basic_hold: got %h", obs); end
  endtask

  task automatic test_ties();
    send(1, 0, 5, 30);
    send(0, 0, 6, 30);
    send(0, 1, 7, 30);
    idle();
    n_cmp++; if (obs !== {1'b1, 16'd5, 14'd30, 16'd6, 14'd30, 17'd3})
      begin n_err++; $display("FAIL ties_result: got %h want %h", obs, {1'b1, 16'd5, 14'd30, 16'd6, 14'd30, 17'd3}); end
  endtask

  task automatic test_single();
    idle();
    send(1, 1, 9, 100);
    n_cmp++; if ({trig, busy} !== 2'b00) begin n_err++; $display("FAIL single_early: got trig,busy=%b want 00", {trig, busy}); end
    idle();
    n_cmp++; if (obs !== {1'b1, 16'd9, 14'd100, 16'hFFFF, 14'h3FFF, 17'd1})
      begin n_err++; $display("FAIL single_result: got %h want %h", obs, {1'b1, 16'd9, 14'd100, 16'hFFFF, 14'h3FFF, 17'd1}); end
  endtask

  task automatic test_abort_b2b();
    idle();
    send(1, 0, 0, 5);
    send(0, 0, 1, 3);
    send(1, 0, 2, 40);
    n_cmp++; if ({trig, busy} !== 2'b01) begin n_err++; $display("FAIL abort_no_trig: got trig,busy=%b want 01", {trig, busy}); end
    send(0, 1, 3, 60);
    n_cmp++; if (trig !== 1'b0) begin n_err++; $display("FAIL abort_no_trig2: got %b want 0", trig); end
    send(1, 1, 4, 1);
    n_cmp++; if (obs !== {1'b1, 16'd2, 14'd40, 16'd3, 14'd60, 17'd2})
      begin n_err++; $display("FAIL b2b_first: got %h want %h", obs, {1'b1, 16'd2, 14'd40, 16'd3, 14'd60, 17'd2}); end
    idle();
    n_cmp++; if (obs !== {1'b1, 16'd4, 14'd1, 16'hFFFF, 14'h3FFF, 17'd1})
      begin n_err++; $display("FAIL b2b_second: got %h want %h", obs, {1'b1, 16'd4, 14'd1, 16'hFFFF, 14'h3FFF, 17'd1}); end
    idle();
    n_cmp++; if (trig !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", trig); end
  endtask

  task automatic test_gap();
    send(1, 0, 0, 'h3FFF);
    for (int i = 0; i < 5; i++) begin
      idle();
      n_cmp++; if ({trig, busy} !== 2'b01) begin n_err++; $display("FAIL gap_idle%0d: got trig,busy=%b want 01", i, {trig, busy}); end
    end
    send(0, 1, 1, 0);
    n_cmp++; if (trig !== 1'b0) begin n_err++; $display("FAIL gap_early: got %b want 0", trig); end
    idle();
    n_cmp++; if (obs !== {1'b1, 16'd1, 14'd0, 16'd0, 14'h3FFF, 17'd2})
      begin n_err++; $display("FAIL gap_result: got %h want %h", obs, {1'b1, 16'd1, 14'd0, 16'd0, 14'h3FFF, 17'd2}); end
  endtask

  task automatic test_reset();
    send(1, 0, 0, 50);
    send(0, 0, 1, 20);
    send(0, 1, 2, 70);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({obs, busy} !== 79'd0) begin n_err++; $display("FAIL reset_clear: got %h want 0", {obs, busy}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_cmp++; if ({obs, busy} !== 79'd0) begin n_err++; $display("FAIL reset_quiet%0d: got %h want 0", i, {obs, busy}); end
    end
    send(1, 0, 10, 7);
    send(0, 1, 11, 2);
    idle();
    n_cmp++; if (obs !== {1'b1, 16'd11, 14'd2, 16'd10, 14'd7, 17'd2})
      begin n_err++; $display("FAIL reset_next_frame: got %h want %h", obs, {1'b1, 16'd11, 14'd2, 16'd10, 14'd7, 17'd2}); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_start = ($urandom_range(0, 9) < 2);
      in_last  = ($urandom_range(0, 9) < 2);
      in_index = IDX_W'($urandom);
      in_value = ($urandom_range(0, 7) == 0) ? 14'h3FFF : VAL_W'($urandom_range(0, 7));
      @(posedge clk); #1;
      n_cmp++; if (obs !== {exp_trig, e1, e2, ecnt})
        begin n_err++; $display("FAIL rand_out c=%0d: got %h want %h", c, obs, {exp_trig, e1, e2, ecnt}); end
      n_cmp++; if (busy !== exp_busy)
        begin n_err++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, exp_busy); end
    end
    idle();
    idle();
  endtask

  initial begin
    test_por();
    test_basic();
    test_ties();
    test_single();
    test_abort_b2b();
    test_gap();
    test_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
